// File: rtl/ldl_parity_arb.sv
// Packet-granular round-robin arbiter in front of one shared byte-parity checker.
// The grant is held from the first beat to EOP, then the checker's error flag is
// sampled for one cycle and reported with the source id. A sticky error flag is
// kept for each source.
module ldl_parity_arb #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned BYTE_NUM   = DATA_WIDTH / 8,
  parameter int unsigned BN_W       = $clog2(BYTE_NUM),
  parameter int unsigned ID_W       = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            s_valid,
  output logic [NUM_SRC-1:0]            s_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SRC*BN_W-1:0]       s_bnum,
  input  logic [NUM_SRC-1:0]            s_eop,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [BN_W-1:0]               m_bnum,
  output logic                          m_eop,
  output logic [ID_W-1:0]               m_src,
  input  logic                          chk_err,
  output logic                          res_valid,
  output logic [ID_W-1:0]               res_src,
  output logic                          res_err,
  output logic [NUM_SRC-1:0]            err_flag,
  input  logic [NUM_SRC-1:0]            err_clr
);

  typedef enum logic [1:0] {StIdle, StBusy, StCheck} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    rr_pick;
  logic               rr_found;
  logic [NUM_SRC-1:0] err_flag_q, err_flag_d, err_set;

  // Round-robin search: first requester at or after last_q + 1, wrapping.
  always_comb begin
    int unsigned idx;
    rr_found = 1'b0;
    rr_pick  = '0;
    idx      = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(last_q) + k) % NUM_SRC;
      if (!rr_found && s_valid[idx]) begin
        rr_found = 1'b1;
        rr_pick  = ID_W'(idx);
      end
    end
  end

  // Next-state logic and all datapath/handshake outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    s_ready   = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_bnum    = '0;
    m_eop     = 1'b0;
    m_src     = '0;
    res_valid = 1'b0;
    res_src   = '0;
    res_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        s_ready[grant_q] = 1'b1;
        m_valid          = s_valid[grant_q];
        m_data           = s_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_bnum           = s_bnum[grant_q*BN_W +: BN_W];
        m_eop            = s_eop[grant_q];
        m_src            = grant_q;
        // A stalled source keeps the grant; only an accepted EOP releases it.
        if (s_valid[grant_q] && s_eop[grant_q]) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        // The checker's flag is valid exactly one cycle after the EOP beat.
        res_valid = 1'b1;
        res_src   = grant_q;
        res_err   = chk_err;
        last_d    = grant_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      err_set[i] = res_valid && res_err && (res_src == ID_W'(i));
    end
    err_flag_d = (err_flag_q & ~err_clr) | err_set;
  end

  assign err_flag = err_flag_q;

  // State registers; last_q resets to the top source so source 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      last_q     <= ID_W'(NUM_SRC - 1);
      err_flag_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      err_flag_q <= err_flag_d;
    end
  end

endmodule

// File: tb/tb_ldl_parity_arb.sv
// Self-checking bench for ldl_parity_arb: per-source packet drivers, a result
// scoreboard filled in the order the arbiter must serve packets, and a monitor.
module tb_ldl_parity_arb;

  localparam int NS   = 4;
  localparam int DW   = 256;
  localparam int BN_W = 5;
  localparam int ID_W = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NS-1:0]      s_valid = '0;
  logic [NS-1:0]      s_ready;
  logic [NS*DW-1:0]   s_data = '0;
  logic [NS*BN_W-1:0] s_bnum = '0;
  logic [NS-1:0]      s_eop = '0;
  logic               m_valid;
  logic [DW-1:0]      m_data;
  logic [BN_W-1:0]    m_bnum;
  logic               m_eop;
  logic [ID_W-1:0]    m_src;
  logic               chk_err = 1'b0;
  logic               res_valid;
  logic [ID_W-1:0]    res_src;
  logic               res_err;
  logic [NS-1:0]      err_flag;
  logic [NS-1:0]      err_clr = '0;

  ldl_parity_arb #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_bnum(s_bnum), .s_eop(s_eop),
    .m_valid(m_valid), .m_data(m_data), .m_bnum(m_bnum), .m_eop(m_eop), .m_src(m_src),
    .chk_err(chk_err), .res_valid(res_valid), .res_src(res_src), .res_err(res_err),
    .err_flag(err_flag), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] src;
    logic            err;
  } res_t;

  res_t exp_q[$];
  int   res_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Source driver state.
  int              pkts_left [NS];
  int              len       [NS];
  int              beat      [NS];
  int              stall_beat[NS];
  int              stall_cnt [NS];
  int              stall_len [NS];
  logic [BN_W-1:0] pkt_bnum  [NS];
  logic            pkt_err   [NS];
  logic            clr_chk   [NS];
  logic            clr_req   [NS];
  logic [DW-1:0]   drv_data  [NS];
  logic [BN_W-1:0] drv_bnum  [NS];
  logic            drv_eop   [NS];
  logic [NS-1:0]   acc = '0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_src(input int i, input int n, input int l, input int bn, input bit e,
                           input bit clrc);
    len[i]        = l;
    beat[i]       = 0;
    pkt_bnum[i]   = BN_W'(bn);
    pkt_err[i]    = e;
    clr_chk[i]    = clrc;
    stall_beat[i] = -1;
    stall_cnt[i]  = 0;
    pkts_left[i]  = n;
  endtask

  task automatic push_exp(input int src, input bit e);
    res_t r;
    r.src = ID_W'(src);
    r.err = e;
    exp_q.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    int left;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk); #1;
      left = 0;
      for (int i = 0; i < NS; i++) left += pkts_left[i];
      done = (exp_q.size() == 0) && (left == 0);
    end
    check_eq("idle_timeout", DW'(done), DW'(1));
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Source driver: advances on accepted beats, drives fresh random data each cycle.
  initial begin
    for (int i = 0; i < NS; i++) begin
      pkts_left[i] = 0; len[i] = 1; beat[i] = 0; stall_beat[i] = -1; stall_cnt[i] = 0;
      stall_len[i] = 0; pkt_bnum[i] = '0; pkt_err[i] = 1'b0; clr_chk[i] = 1'b0;
      clr_req[i] = 1'b0; drv_data[i] = '0; drv_bnum[i] = '0; drv_eop[i] = 1'b0;
    end
    forever begin
      @(posedge clk); #1;
      chk_err = 1'b0;
      err_clr = '0;
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) begin
          if (beat[i] == len[i] - 1) begin
            beat[i] = 0;
            pkts_left[i]--;
            if (pkt_err[i]) chk_err = 1'b1;
            if (clr_chk[i]) err_clr[i] = 1'b1;
          end else begin
            beat[i]++;
            if (beat[i] == stall_beat[i]) begin
              stall_cnt[i]  = stall_len[i];
              stall_beat[i] = -1;
            end
          end
        end
        if (clr_req[i]) begin
          err_clr[i] = 1'b1;
          clr_req[i] = 1'b0;
        end
        if (stall_cnt[i] > 0) begin
          stall_cnt[i]--;
          s_valid[i] = 1'b0;
        end else begin
          s_valid[i] = (pkts_left[i] > 0);
        end
        for (int w = 0; w < DW / 32; w++) drv_data[i][w*32 +: 32] = $urandom();
        drv_eop[i]  = (beat[i] == len[i] - 1);
        drv_bnum[i] = drv_eop[i] ? pkt_bnum[i] : BN_W'($urandom_range(0, 31));
        s_data[i*DW +: DW]     = drv_data[i];
        s_bnum[i*BN_W +: BN_W] = drv_bnum[i];
        s_eop[i]               = drv_eop[i];
      end
    end
  end

  // Monitor: scoreboard for results, beat forwarding and grant exclusivity.
  initial forever begin
    res_t          e;
    int            src;
    logic [NS-1:0] oh;
    @(negedge clk);
    acc = s_valid & s_ready;
    if (res_valid) res_cyc.push_back(cyc);
    if (exp_q.size() == 0) begin
      check_eq("res_unexpected", DW'(res_valid), DW'(0));
      check_eq("beat_unexpected", DW'(m_valid), DW'(0));
      check_eq("s_ready_idle", DW'(s_ready), DW'(0));
    end else begin
      src = int'(exp_q[0].src);
      oh  = NS'(1) << src;
      if (s_ready != '0) check_eq("s_ready_onehot", DW'(s_ready), DW'(oh));
      if (res_valid) begin
        e = exp_q.pop_front();
        check_eq("res_src", DW'(res_src), DW'(e.src));
        check_eq("res_err", DW'(res_err), DW'(e.err));
      end else if (m_valid) begin
        check_eq("m_src", DW'(m_src), DW'(src));
        check_eq("m_data", m_data, drv_data[src]);
        check_eq("m_bnum", DW'(m_bnum), DW'(drv_bnum[src]));
        check_eq("m_eop", DW'(m_eop), DW'(drv_eop[src]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   beats;
    logic [BN_W-1:0] bn_seen;
    bit   got_res;
    bit   ok;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_s_ready", DW'(s_ready), DW'(0));
    check_eq("rst_m_valid", DW'(m_valid), DW'(0));
    check_eq("rst_m_data", m_data, DW'(0));
    check_eq("rst_res_valid", DW'(res_valid), DW'(0));
    check_eq("rst_err_flag", DW'(err_flag), DW'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Single 3-beat packet from source 2, bnum 5.
    push_exp(2, 1'b0);
    start_src(2, 1, 3, 5, 1'b0, 1'b0);
    @(negedge clk); #1;
    check_eq("t1_ready_req_cycle", DW'(s_ready), DW'(0));
    @(negedge clk); #1;
    check_eq("t1_ready_next_cycle", DW'(s_ready), DW'(4'b0100));
    check_eq("t1_m_src", DW'(m_src), DW'(2));
    beats   = m_valid ? 1 : 0;
    bn_seen = '0;
    got_res = 1'b0;
    for (int c = 0; c < 10 && !got_res; c++) begin
      @(negedge clk); #1;
      if (m_valid) beats++;
      if (m_valid && m_eop) bn_seen = m_bnum;
      if (res_valid) got_res = 1'b1;
    end
    check_eq("t1_beats", DW'(beats), DW'(3));
    check_eq("t1_eop_bnum", DW'(bn_seen), DW'(5));
    check_eq("t1_res_seen", DW'(got_res), DW'(1));
    wait_idle(20);
    check_eq("t1_err_flag", DW'(err_flag), DW'(0));

    // All four sources, continuous 1-beat packets; last grant was 2.
    res_cyc.delete();
    foreach (exp_q[k]) exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      push_exp(3, 1'b0); push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(2, 1'b0);
    end
    for (int i = 0; i < NS; i++) start_src(i, 2, 1, i + 1, 1'b0, 1'b0);
    wait_idle(60);
    check_eq("t2_res_count", DW'(res_cyc.size()), DW'(8));
    for (int k = 1; k < res_cyc.size(); k++) begin
      check_eq("t2_res_spacing", DW'(res_cyc[k] - res_cyc[k-1]), DW'(3));
    end

    // Source 1 stalls 5 cycles mid-packet while source 3 requests.
    push_exp(1, 1'b0);
    push_exp(3, 1'b0);
    start_src(1, 1, 3, 7, 1'b0, 1'b0);
    stall_beat[1] = 1;
    stall_len[1]  = 5;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); #1;
      ok = s_ready[1] && s_valid[1];
    end
    check_eq("t3_grant1", DW'(ok), DW'(1));
    start_src(3, 1, 1, 2, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check_eq("t3_stall_m_valid", DW'(m_valid), DW'(0));
      check_eq("t3_stall_m_src", DW'(m_src), DW'(1));
      check_eq("t3_stall_ready", DW'(s_ready), DW'(4'b0010));
    end
    wait_idle(40);

    // Parity error on source 0, sticky until cleared; set beats same-cycle clear.
    push_exp(0, 1'b1);
    start_src(0, 1, 2, 3, 1'b1, 1'b0);
    wait_idle(30);
    check_eq("t4_err_set", DW'(err_flag), DW'(4'b0001));
    repeat (3) @(negedge clk);
    #1;
    check_eq("t4_err_held", DW'(err_flag), DW'(4'b0001));
    clr_req[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("t4_err_cleared", DW'(err_flag), DW'(0));
    push_exp(0, 1'b1);
    start_src(0, 1, 1, 4, 1'b1, 1'b1);
    wait_idle(30);
    check_eq("t4_set_wins", DW'(err_flag), DW'(4'b0001));

    // Wrap: make source 3 the last grant, then 0 and 3 request together.
    push_exp(3, 1'b0);
    start_src(3, 1, 1, 1, 1'b0, 1'b0);
    wait_idle(30);
    push_exp(0, 1'b0);
    push_exp(3, 1'b0);
    start_src(0, 1, 2, 6, 1'b0, 1'b0);
    start_src(3, 1, 1, 9, 1'b0, 1'b0);
    wait_idle(40);

    // Async reset mid-packet: last grant 1, then source 2 aborted after 2 of 4 beats.
    push_exp(1, 1'b0);
    start_src(1, 1, 1, 1, 1'b0, 1'b0);
    wait_idle(30);
    push_exp(2, 1'b0);
    start_src(2, 1, 4, 8, 1'b0, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); #1;
      ok = (beat[2] == 2);
    end
    check_eq("t6_two_beats", DW'(ok), DW'(1));
    #1;
    rst = 1'b0;
    for (int i = 0; i < NS; i++) begin
      pkts_left[i] = 0; stall_cnt[i] = 0; beat[i] = 0; clr_req[i] = 1'b0;
    end
    s_valid = '0;
    acc     = '0;
    chk_err = 1'b0;
    err_clr = '0;
    exp_q.delete();
    #1;
    check_eq("t6_rst_s_ready", DW'(s_ready), DW'(0));
    check_eq("t6_rst_m_valid", DW'(m_valid), DW'(0));
    check_eq("t6_rst_m_data", m_data, DW'(0));
    check_eq("t6_rst_m_meta", DW'({m_bnum, m_eop, m_src}), DW'(0));
    check_eq("t6_rst_res", DW'({res_valid, res_src, res_err}), DW'(0));
    check_eq("t6_rst_err_flag", DW'(err_flag), DW'(0));
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    push_exp(0, 1'b0);
    push_exp(2, 1'b0);
    start_src(0, 1, 1, 2, 1'b0, 1'b0);
    start_src(2, 1, 1, 3, 1'b0, 1'b0);
    wait_idle(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
